// File: rtl/jala_control_fsm_if.sv
// Control bundle between the JALA control FSM (master) and the stage5 datapath (slave).
// Carries the decoded instruction and top-of-stack value in, and every control strobe out.
interface jala_control_fsm_if;
    logic [15:0] IROut;
    logic [15:0] ValAOut;
    logic        MSPWrite;
    logic        MSPPop;
    logic        RSPWrite;
    logic        RSPPop;
    logic        PCWrite;
    logic        PCSource;
    logic        PCAdd;
    logic        ValAWrite;
    logic        ValBWrite;
    logic        IRWrite;
    logic        MemRead1;
    logic        MemRead2;
    logic        MemWrite1;
    logic        MemWrite2;
    logic [1:0]  MemDst1;
    logic [1:0]  MemDst2;
    logic [2:0]  MemData;
    logic        Halted;
    logic        Illegal;
    logic [2:0]  StateOut;

    modport master (
        input  IROut, ValAOut,
        output MSPWrite, MSPPop, RSPWrite, RSPPop,
        output PCWrite, PCSource, PCAdd,
        output ValAWrite, ValBWrite, IRWrite,
        output MemRead1, MemRead2, MemWrite1, MemWrite2,
        output MemDst1, MemDst2, MemData,
        output Halted, Illegal, StateOut
    );

    modport slave (
        output IROut, ValAOut,
        input  MSPWrite, MSPPop, RSPWrite, RSPPop,
        input  PCWrite, PCSource, PCAdd,
        input  ValAWrite, ValBWrite, IRWrite,
        input  MemRead1, MemRead2, MemWrite1, MemWrite2,
        input  MemDst1, MemDst2, MemData,
        input  Halted, Illegal, StateOut
    );
endinterface

// File: rtl/jala_control_fsm.sv
// Multicycle control FSM for the JALA stack CPU (INIT/FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional feature: define JALA_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with a sticky Illegal flag.
module jala_control_fsm #(
    parameter int unsigned INIT_CYCLES = 5
) (
    input  logic               CLK,
    input  logic               Reset,
    jala_control_fsm_if.master ctrl
);
    localparam logic [2:0] INIT   = 3'b000;
    localparam logic [2:0] FETCH  = 3'b001;
    localparam logic [2:0] DECODE = 3'b010;
    localparam logic [2:0] EXEC   = 3'b011;
    localparam logic [2:0] MEM    = 3'b100;
    localparam logic [2:0] WB     = 3'b101;
    localparam logic [2:0] HALT   = 3'b111;

    localparam logic [3:0] OP_PUSHI = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_JUMP  = 4'h5;
    localparam logic [3:0] OP_BEQZ  = 4'h6;
    localparam logic [3:0] OP_CALL  = 4'h7;
    localparam logic [3:0] OP_RET   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int unsigned CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;

    logic [2:0]       state;
    logic [2:0]       stateNext;
    logic [3:0]       opcode;
    logic [3:0]       irOp;
    logic [CNT_W-1:0] initCnt;
    logic             unusedIrLow;

    assign irOp        = ctrl.IROut[15:12];
    assign unusedIrLow = ^ctrl.IROut[11:0];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= INIT;
            opcode  <= '0;
            initCnt <= CNT_W'(INIT_CYCLES);
        end else begin
            state <= stateNext;
            if (state == DECODE)
                opcode <= irOp;
            if (state == INIT && initCnt != '0)
                initCnt <= initCnt - CNT_W'(1);
        end
    end

`ifdef JALA_ILLEGAL_TRAP_EN
    logic irIllegal;
    logic illegalQ;

    assign irIllegal = (irOp > OP_RET) && (irOp != OP_HALT);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            illegalQ <= 1'b0;
        else if (state == DECODE && irIllegal)
            illegalQ <= 1'b1;
    end

    assign ctrl.Illegal = illegalQ;
`else
    assign ctrl.Illegal = 1'b0;
`endif

    // INIT leaves on count 1 so INIT_CYCLES cycles are spent there (minimum one, the reset state itself).
    always_comb begin
        stateNext = state;
        case (state)
            INIT:   if (initCnt <= CNT_W'(1)) stateNext = FETCH;
            FETCH:  stateNext = DECODE;
            DECODE: begin
                stateNext = EXEC;
                if (irOp == OP_HALT) stateNext = HALT;
`ifdef JALA_ILLEGAL_TRAP_EN
                if (irIllegal) stateNext = HALT;
`endif
            end
            EXEC: begin
                case (opcode)
                    OP_PUSHI, OP_LOAD, OP_STORE, OP_CALL, OP_RET: stateNext = MEM;
                    OP_ADD, OP_SUB:                               stateNext = WB;
                    default:                                      stateNext = FETCH;
                endcase
            end
            MEM:     stateNext = (opcode == OP_PUSHI || opcode == OP_STORE) ? FETCH : WB;
            WB:      stateNext = FETCH;
            HALT:    stateNext = HALT;
            default: stateNext = INIT;
        endcase
    end

    always_comb begin
        ctrl.MSPWrite  = 1'b0;
        ctrl.MSPPop    = 1'b0;
        ctrl.RSPWrite  = 1'b0;
        ctrl.RSPPop    = 1'b0;
        ctrl.PCWrite   = 1'b0;
        ctrl.PCSource  = 1'b0;
        ctrl.PCAdd     = 1'b0;
        ctrl.ValAWrite = 1'b0;
        ctrl.ValBWrite = 1'b0;
        ctrl.IRWrite   = 1'b0;
        ctrl.MemRead1  = 1'b0;
        ctrl.MemRead2  = 1'b0;
        ctrl.MemWrite1 = 1'b0;
        ctrl.MemWrite2 = 1'b0;
        ctrl.MemDst1   = 2'b00;
        ctrl.MemDst2   = 2'b00;
        ctrl.MemData   = 3'b000;
        case (state)
            FETCH: begin
                ctrl.MemRead1 = 1'b1;
                ctrl.IRWrite  = 1'b1;
                ctrl.PCWrite  = 1'b1;
                ctrl.PCAdd    = 1'b1;
            end
            DECODE: begin
                ctrl.MemDst1   = 2'b01;
                ctrl.MemRead1  = 1'b1;
                ctrl.ValAWrite = 1'b1;
                ctrl.MemDst2   = 2'b01;
                ctrl.MemRead2  = 1'b1;
                ctrl.ValBWrite = 1'b1;
            end
            EXEC: begin
                case (opcode)
                    OP_PUSHI: ctrl.MSPWrite = 1'b1;
                    OP_ADD, OP_SUB, OP_STORE: begin
                        ctrl.MSPWrite = 1'b1;
                        ctrl.MSPPop   = 1'b1;
                    end
                    OP_JUMP: begin
                        ctrl.PCWrite  = 1'b1;
                        ctrl.PCSource = 1'b1;
                    end
                    OP_BEQZ: begin
                        ctrl.MSPWrite = 1'b1;
                        ctrl.MSPPop   = 1'b1;
                        if (ctrl.ValAOut == '0) begin
                            ctrl.PCWrite  = 1'b1;
                            ctrl.PCSource = 1'b1;
                        end
                    end
                    OP_CALL: ctrl.RSPWrite = 1'b1;
                    default: ;
                endcase
            end
            MEM: begin
                case (opcode)
                    OP_PUSHI: begin
                        ctrl.MemDst1   = 2'b01;
                        ctrl.MemData   = 3'b011;
                        ctrl.MemWrite1 = 1'b1;
                    end
                    OP_LOAD: begin
                        ctrl.MemDst1   = 2'b11;
                        ctrl.MemRead1  = 1'b1;
                        ctrl.ValAWrite = 1'b1;
                    end
                    OP_STORE: begin
                        ctrl.MemDst1   = 2'b11;
                        ctrl.MemData   = 3'b001;
                        ctrl.MemWrite1 = 1'b1;
                        ctrl.MSPWrite  = 1'b1;
                        ctrl.MSPPop    = 1'b1;
                    end
                    OP_CALL: begin
                        ctrl.MemDst2   = 2'b10;
                        ctrl.MemData   = 3'b101;
                        ctrl.MemWrite2 = 1'b1;
                    end
                    OP_RET: begin
                        ctrl.MemDst1   = 2'b10;
                        ctrl.MemRead1  = 1'b1;
                        ctrl.ValAWrite = 1'b1;
                    end
                    default: ;
                endcase
            end
            WB: begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        ctrl.MemDst1   = 2'b01;
                        ctrl.MemData   = 3'b010;
                        ctrl.MemWrite1 = 1'b1;
                    end
                    OP_LOAD: begin
                        ctrl.MemDst1   = 2'b01;
                        ctrl.MemWrite1 = 1'b1;
                    end
                    OP_CALL: begin
                        ctrl.PCWrite  = 1'b1;
                        ctrl.PCSource = 1'b1;
                    end
                    OP_RET: begin
                        ctrl.PCWrite  = 1'b1;
                        ctrl.PCSource = 1'b1;
                        ctrl.RSPWrite = 1'b1;
                        ctrl.RSPPop   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign ctrl.Halted   = (state == HALT);
    assign ctrl.StateOut = state;
endmodule

// File: tb/tb_jala_control_fsm.sv
// Self-checking bench for jala_control_fsm: per-instruction cycle-by-cycle expected strobe
// sequences built from the instruction-level rules, directed corner cases plus a random program.
module tb_jala_control_fsm;
    localparam int unsigned TB_INIT = 5;
    localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd7;

    typedef struct packed {
        logic mspWrite, mspPop, rspWrite, rspPop;
        logic pcWrite, pcSource, pcAdd;
        logic valAWrite, valBWrite, irWrite;
        logic memRead1, memRead2, memWrite1, memWrite2;
        logic [1:0] memDst1, memDst2;
        logic [2:0] memData;
        logic halted, illegal;
        logic [2:0] state;
    } ctl_t;

    logic CLK = 1'b0;
    logic Reset;
    int   nTests = 0;
    int   nFail  = 0;
    ctl_t expQ[$];
    logic endsHalted;

    jala_control_fsm_if bus ();

    jala_control_fsm #(.INIT_CYCLES(TB_INIT)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .ctrl  (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%07h exp=%07h", tag, got, exp);
        end
    endtask

    function automatic ctl_t sampleCtl();
        ctl_t c;
        c.mspWrite  = bus.MSPWrite;  c.mspPop    = bus.MSPPop;
        c.rspWrite  = bus.RSPWrite;  c.rspPop    = bus.RSPPop;
        c.pcWrite   = bus.PCWrite;   c.pcSource  = bus.PCSource;  c.pcAdd = bus.PCAdd;
        c.valAWrite = bus.ValAWrite; c.valBWrite = bus.ValBWrite; c.irWrite = bus.IRWrite;
        c.memRead1  = bus.MemRead1;  c.memRead2  = bus.MemRead2;
        c.memWrite1 = bus.MemWrite1; c.memWrite2 = bus.MemWrite2;
        c.memDst1   = bus.MemDst1;   c.memDst2   = bus.MemDst2;   c.memData = bus.MemData;
        c.halted    = bus.Halted;    c.illegal   = bus.Illegal;   c.state = bus.StateOut;
        return c;
    endfunction

    function automatic ctl_t blank(input logic [2:0] st);
        ctl_t c;
        c = '0;
        c.state  = st;
        c.halted = (st == S_HALT);
        return c;
    endfunction

    // Reference model: the full cycle sequence one instruction produces, starting at FETCH.
    task automatic buildExpect(input logic [3:0] op, input logic [15:0] val);
        ctl_t c;
        logic trap;
`ifdef JALA_ILLEGAL_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        expQ.delete();
        endsHalted = 1'b0;
        c = blank(S_FETCH);
        c.memRead1 = 1; c.irWrite = 1; c.pcWrite = 1; c.pcAdd = 1;
        expQ.push_back(c);
        c = blank(S_DECODE);
        c.memDst1 = 2'b01; c.memRead1 = 1; c.valAWrite = 1;
        c.memDst2 = 2'b01; c.memRead2 = 1; c.valBWrite = 1;
        expQ.push_back(c);
        if (op == 4'hF || (op > 4'h8 && trap)) begin
            endsHalted = 1'b1;
            c = blank(S_HALT);
            c.illegal = (op != 4'hF);
            repeat (22) expQ.push_back(c);
            return;
        end
        c = blank(S_EXEC);
        case (op)
            4'h0: begin
                c.mspWrite = 1; expQ.push_back(c);
                c = blank(S_MEM); c.memDst1 = 2'b01; c.memData = 3'b011; c.memWrite1 = 1; expQ.push_back(c);
            end
            4'h1, 4'h2: begin
                c.mspWrite = 1; c.mspPop = 1; expQ.push_back(c);
                c = blank(S_WB); c.memDst1 = 2'b01; c.memData = 3'b010; c.memWrite1 = 1; expQ.push_back(c);
            end
            4'h3: begin
                expQ.push_back(c);
                c = blank(S_MEM); c.memDst1 = 2'b11; c.memRead1 = 1; c.valAWrite = 1; expQ.push_back(c);
                c = blank(S_WB); c.memDst1 = 2'b01; c.memData = 3'b000; c.memWrite1 = 1; expQ.push_back(c);
            end
            4'h4: begin
                c.mspWrite = 1; c.mspPop = 1; expQ.push_back(c);
                c = blank(S_MEM); c.memDst1 = 2'b11; c.memData = 3'b001; c.memWrite1 = 1;
                c.mspWrite = 1; c.mspPop = 1; expQ.push_back(c);
            end
            4'h5: begin
                c.pcWrite = 1; c.pcSource = 1; expQ.push_back(c);
            end
            4'h6: begin
                c.mspWrite = 1; c.mspPop = 1;
                c.pcWrite = (val == 16'd0); c.pcSource = (val == 16'd0);
                expQ.push_back(c);
            end
            4'h7: begin
                c.rspWrite = 1; expQ.push_back(c);
                c = blank(S_MEM); c.memDst2 = 2'b10; c.memData = 3'b101; c.memWrite2 = 1; expQ.push_back(c);
                c = blank(S_WB); c.pcWrite = 1; c.pcSource = 1; expQ.push_back(c);
            end
            4'h8: begin
                expQ.push_back(c);
                c = blank(S_MEM); c.memDst1 = 2'b10; c.memRead1 = 1; c.valAWrite = 1; expQ.push_back(c);
                c = blank(S_WB); c.pcWrite = 1; c.pcSource = 1; c.rspWrite = 1; c.rspPop = 1; expQ.push_back(c);
            end
            default: expQ.push_back(c);
        endcase
    endtask

    task automatic runSeq(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            checkVal($sformatf("%s.cyc%0d", name, i), 32'(sampleCtl()), 32'(expQ[i]));
            checkVal($sformatf("%s.wrexcl%0d", name, i), 32'(bus.MemWrite1 & bus.MemWrite2), 32'd0);
            @(posedge CLK); #1;
        end
    endtask

    task automatic releaseReset();
        @(posedge CLK); #1;
        Reset = 1'b0;
        for (int i = 0; i < ((TB_INIT == 0) ? 1 : int'(TB_INIT)); i++) begin
            @(negedge CLK);
            checkVal($sformatf("init.cyc%0d", i), 32'(sampleCtl()), 32'(blank(S_INIT)));
            @(posedge CLK); #1;
        end
    endtask

    task automatic doReset();
        Reset = 1'b1;
        @(negedge CLK);
        checkVal("reset.hold", 32'(sampleCtl()), 32'(blank(S_INIT)));
        releaseReset();
    endtask

    task automatic runInstr(input logic [3:0] op, input logic [15:0] val, input string name);
        bus.IROut   = {op, 12'($urandom)};
        bus.ValAOut = val;
        buildExpect(op, val);
        runSeq(name, expQ.size());
        if (endsHalted) doReset();
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] val;
        Reset       = 1'b1;
        bus.IROut   = '0;
        bus.ValAOut = '0;
        repeat (2) @(posedge CLK);
        #1;
        doReset();

        runInstr(4'h1, 16'($urandom), "add");
        runInstr(4'h6, 16'h0000, "beqz0");
        runInstr(4'h6, 16'h0003, "beqz3");
        runInstr(4'h7, 16'($urandom), "call");
        runInstr(4'h8, 16'($urandom), "ret");

        // Reset asserted in the MEM cycle of STORE must kill the write strobe immediately.
        bus.IROut   = 16'h4000;
        bus.ValAOut = 16'h1234;
        buildExpect(4'h4, 16'h1234);
        runSeq("store", 3);
        @(negedge CLK);
        checkVal("store.mem", 32'(sampleCtl()), 32'(expQ[3]));
        Reset = 1'b1;
        #1;
        checkVal("store.abort", 32'(sampleCtl()), 32'(blank(S_INIT)));
        releaseReset();

        runInstr(4'hA, 16'($urandom), "illegal");
        runInstr(4'hF, 16'($urandom), "halt");

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(9, 14));
            else                           op = 4'($urandom_range(0, 8));
            val = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
            runInstr(op, val, $sformatf("rnd%0d.op%0h", k, op));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
